ivalu_issue_queue: RTL and testbench

Age-ordered issue queue for the vector integer ALU. It accepts dispatched vector ALU micro-ops with possibly-unready operands and snoops two writeback buses to capture operand data. Each cycle it selects the oldest fully-ready entry and issues it, registered, to the single-cycle `ivalu` through its `a/b/op/rob_i/dest_i/valid_i` inputs. It sits between rename/dispatch and `ivalu`; the `ivalu` result bus feeds back as wakeup port 0.

---
 rtl/ivalu_issue_queue_if.sv | 43 ++++
 rtl/ivalu_issue_queue.sv | 191 +++++++++++++++++++
 tb/tb_ivalu_issue_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ivalu_issue_queue_if.sv
// ivalu_issue_queue_if: dispatch, writeback-snoop and issue signals of the
// vector integer ALU issue queue.
//   master : dispatch/wakeup/flush driver, observes issue and occupancy
//   slave  : the issue queue itself
// Signal names keep the block-level _i/_o suffixes seen from the queue.
interface ivalu_issue_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush_i;
  logic          disp_valid_i;
  logic          disp_ready_o;
  logic [6:0]    disp_op_i;
  logic [4:0]    disp_rob_i;
  logic [5:0]    disp_dest_i;
  logic [31:0]   disp_a_i, disp_b_i;
  logic          disp_a_rdy_i, disp_b_rdy_i;
  logic [5:0]    disp_a_tag_i, disp_b_tag_i;
  logic          wk0_valid_i, wk1_valid_i;
  logic [5:0]    wk0_tag_i, wk1_tag_i;
  logic [31:0]   wk0_data_i, wk1_data_i;
  logic          iss_valid_o;
  logic [31:0]   iss_a_o, iss_b_o;
  logic [6:0]    iss_op_o;
  logic [4:0]    iss_rob_o;
  logic [5:0]    iss_dest_o;
  logic [CW-1:0] occupancy_o;

  modport master (
    output flush_i, disp_valid_i, disp_op_i, disp_rob_i, disp_dest_i,
           disp_a_i, disp_b_i, disp_a_rdy_i, disp_b_rdy_i, disp_a_tag_i, disp_b_tag_i,
           wk0_valid_i, wk1_valid_i, wk0_tag_i, wk1_tag_i, wk0_data_i, wk1_data_i,
    input  disp_ready_o, iss_valid_o, iss_a_o, iss_b_o, iss_op_o, iss_rob_o,
           iss_dest_o, occupancy_o
  );

  modport slave (
    input  flush_i, disp_valid_i, disp_op_i, disp_rob_i, disp_dest_i,
           disp_a_i, disp_b_i, disp_a_rdy_i, disp_b_rdy_i, disp_a_tag_i, disp_b_tag_i,
           wk0_valid_i, wk1_valid_i, wk0_tag_i, wk1_tag_i, wk0_data_i, wk1_data_i,
    output disp_ready_o, iss_valid_o, iss_a_o, iss_b_o, iss_op_o, iss_rob_o,
           iss_dest_o, occupancy_o
  );
endinterface

// File: rtl/ivalu_issue_queue.sv
// ivalu_issue_queue: age-ordered issue queue for the vector integer ALU.
// Accepts one dispatched micro-op per cycle, snoops two writeback buses for
// operand data, and issues the oldest fully-ready entry (registered) per cycle.
// Ports:
//   core_clock_i : core clock, rising edge
//   core_reset_i : asynchronous active-low reset
//   bus          : ivalu_issue_queue_if.slave (dispatch, wakeup, flush, issue, occupancy)

// One queue slot: holds the micro-op and captures operand wakeups.
module ivalu_iq_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc,
  input  logic        free,
  input  logic [6:0]  op_in,
  input  logic [4:0]  rob_in,
  input  logic [5:0]  dest_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        a_rdy_in,
  input  logic        b_rdy_in,
  input  logic [5:0]  a_tag_in,
  input  logic [5:0]  b_tag_in,
  input  logic        wk0_valid,
  input  logic [5:0]  wk0_tag,
  input  logic [31:0] wk0_data,
  input  logic        wk1_valid,
  input  logic [5:0]  wk1_tag,
  input  logic [31:0] wk1_data,
  output logic        valid,
  output logic        ready,
  output logic [6:0]  op,
  output logic [4:0]  rob,
  output logic [5:0]  dest,
  output logic [31:0] a,
  output logic [31:0] b
);
  logic       a_rdy, b_rdy;
  logic [5:0] a_tag, b_tag;
  logic       a_hit0, a_hit1, b_hit0, b_hit1;

  assign a_hit0 = wk0_valid && (wk0_tag != '0) && (wk0_tag == a_tag);
  assign a_hit1 = wk1_valid && (wk1_tag != '0) && (wk1_tag == a_tag);
  assign b_hit0 = wk0_valid && (wk0_tag != '0) && (wk0_tag == b_tag);
  assign b_hit1 = wk1_valid && (wk1_tag != '0) && (wk1_tag == b_tag);
  assign ready  = valid & a_rdy & b_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0; a_rdy <= 1'b0; b_rdy <= 1'b0;
      op <= '0; rob <= '0; dest <= '0; a <= '0; b <= '0; a_tag <= '0; b_tag <= '0;
    end else if (free) begin
      valid <= 1'b0;
    end else if (alloc) begin
      valid <= 1'b1;
      op    <= op_in;    rob   <= rob_in;   dest  <= dest_in;
      a     <= a_in;     b     <= b_in;
      a_rdy <= a_rdy_in; b_rdy <= b_rdy_in;
      a_tag <= a_tag_in; b_tag <= b_tag_in;
    end else if (valid) begin
      // port 0 wins when both buses carry the same tag
      if (!a_rdy && (a_hit0 || a_hit1)) begin
        a_rdy <= 1'b1;
        a     <= a_hit0 ? wk0_data : wk1_data;
      end
      if (!b_rdy && (b_hit0 || b_hit1)) begin
        b_rdy <= 1'b1;
        b     <= b_hit0 ? wk0_data : wk1_data;
      end
    end
  end
endmodule

module ivalu_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic               core_clock_i,
  input  logic               core_reset_i,
  ivalu_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             ent_valid, ent_ready, sel, alloc_oh;
  logic [DEPTH-1:0][6:0]        ent_op;
  logic [DEPTH-1:0][4:0]        ent_rob;
  logic [DEPTH-1:0][5:0]        ent_dest;
  logic [DEPTH-1:0][31:0]       ent_a, ent_b;
  // older_than[i][j]: entry j was allocated before entry i
  logic [DEPTH-1:0][DEPTH-1:0]  older_than;
  logic [CW-1:0]                occ;
  logic                         fire, issue;

  // dispatch-side operand resolution: tag 0 is always ready, else same-cycle bypass
  logic        da_t0, db_t0, da_w0, da_w1, db_w0, db_w1, da_rdy, db_rdy;
  logic [31:0] da_val, db_val;

  assign da_t0  = bus.disp_a_tag_i == '0;
  assign db_t0  = bus.disp_b_tag_i == '0;
  assign da_w0  = bus.wk0_valid_i && !da_t0 && (bus.wk0_tag_i == bus.disp_a_tag_i);
  assign da_w1  = bus.wk1_valid_i && !da_t0 && (bus.wk1_tag_i == bus.disp_a_tag_i);
  assign db_w0  = bus.wk0_valid_i && !db_t0 && (bus.wk0_tag_i == bus.disp_b_tag_i);
  assign db_w1  = bus.wk1_valid_i && !db_t0 && (bus.wk1_tag_i == bus.disp_b_tag_i);
  assign da_rdy = bus.disp_a_rdy_i | da_t0 | da_w0 | da_w1;
  assign db_rdy = bus.disp_b_rdy_i | db_t0 | db_w0 | db_w1;
  assign da_val = (bus.disp_a_rdy_i | da_t0) ? bus.disp_a_i :
                  da_w0 ? bus.wk0_data_i : bus.wk1_data_i;
  assign db_val = (bus.disp_b_rdy_i | db_t0) ? bus.disp_b_i :
                  db_w0 ? bus.wk0_data_i : bus.wk1_data_i;

  assign bus.disp_ready_o = occ < CW'(DEPTH);
  assign bus.occupancy_o  = occ;
  assign fire  = bus.disp_valid_i & bus.disp_ready_o & ~bus.flush_i;
  assign issue = (|sel) & ~bus.flush_i;

  // lowest free slot: isolate the lowest set bit of ~valid
  assign alloc_oh = fire ? (~ent_valid & (ent_valid + {{(DEPTH-1){1'b0}}, 1'b1})) : '0;

  // oldest ready: no other ready entry is older
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      sel[i] = ent_ready[i] & ~|(ent_ready & older_than[i]);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    ivalu_iq_entry u_ent (
      .clk(core_clock_i), .rst_n(core_reset_i),
      .alloc(alloc_oh[g]), .free(bus.flush_i | sel[g]),
      .op_in(bus.disp_op_i), .rob_in(bus.disp_rob_i), .dest_in(bus.disp_dest_i),
      .a_in(da_val), .b_in(db_val), .a_rdy_in(da_rdy), .b_rdy_in(db_rdy),
      .a_tag_in(bus.disp_a_tag_i), .b_tag_in(bus.disp_b_tag_i),
      .wk0_valid(bus.wk0_valid_i), .wk0_tag(bus.wk0_tag_i), .wk0_data(bus.wk0_data_i),
      .wk1_valid(bus.wk1_valid_i), .wk1_tag(bus.wk1_tag_i), .wk1_data(bus.wk1_data_i),
      .valid(ent_valid[g]), .ready(ent_ready[g]),
      .op(ent_op[g]), .rob(ent_rob[g]), .dest(ent_dest[g]), .a(ent_a[g]), .b(ent_b[g])
    );
  end

  // one-hot select -> OR mux
  logic [6:0]  mux_op;
  logic [4:0]  mux_rob;
  logic [5:0]  mux_dest;
  logic [31:0] mux_a, mux_b;
  always_comb begin
    mux_op = '0; mux_rob = '0; mux_dest = '0; mux_a = '0; mux_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mux_op   |= {7{sel[i]}}  & ent_op[i];
      mux_rob  |= {5{sel[i]}}  & ent_rob[i];
      mux_dest |= {6{sel[i]}}  & ent_dest[i];
      mux_a    |= {32{sel[i]}} & ent_a[i];
      mux_b    |= {32{sel[i]}} & ent_b[i];
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_i) begin
    if (!core_reset_i) begin
      older_than <= '0;
    end else begin
      // new entry is younger than everything currently valid; nothing is younger than it
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh[k]) begin
          for (int j = 0; j < DEPTH; j++) older_than[j][k] <= 1'b0;
          older_than[k] <= ent_valid;
        end
      end
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_i) begin
    if (!core_reset_i) begin
      occ             <= '0;
      bus.iss_valid_o <= 1'b0;
      bus.iss_a_o     <= '0;
      bus.iss_b_o     <= '0;
      bus.iss_op_o    <= '0;
      bus.iss_rob_o   <= '0;
      bus.iss_dest_o  <= '0;
    end else begin
      if (bus.flush_i) occ <= '0;
      else             occ <= occ + CW'(fire) - CW'(issue);
      bus.iss_valid_o <= issue;
      if (issue) begin
        bus.iss_a_o    <= mux_a;
        bus.iss_b_o    <= mux_b;
        bus.iss_op_o   <= mux_op;
        bus.iss_rob_o  <= mux_rob;
        bus.iss_dest_o <= mux_dest;
      end
    end
  end
endmodule

// File: tb/tb_ivalu_issue_queue.sv
module tb_ivalu_issue_queue;
  localparam int DEPTH = 8;

  logic clk, rst_n;
  int   total, bad;

  ivalu_issue_queue_if #(.DEPTH(DEPTH)) bus ();
  ivalu_issue_queue #(.DEPTH(DEPTH)) dut (.core_clock_i(clk), .core_reset_i(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: entries kept oldest-first in a queue
  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rob;
    logic [5:0]  dest;
    logic [31:0] a, b;
    logic        ar, br;
    logic [5:0]  at, bt;
  } ent_t;
  ent_t        q[$];
  logic        m_iv;
  logic [31:0] m_a, m_b;
  logic [6:0]  m_op;
  logic [4:0]  m_rob;
  logic [5:0]  m_dest;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.flush_i = 0; bus.disp_valid_i = 0; bus.disp_op_i = 0; bus.disp_rob_i = 0;
    bus.disp_dest_i = 0; bus.disp_a_i = 0; bus.disp_b_i = 0; bus.disp_a_rdy_i = 0;
    bus.disp_b_rdy_i = 0; bus.disp_a_tag_i = 0; bus.disp_b_tag_i = 0;
    bus.wk0_valid_i = 0; bus.wk0_tag_i = 0; bus.wk0_data_i = 0;
    bus.wk1_valid_i = 0; bus.wk1_tag_i = 0; bus.wk1_data_i = 0;
  endtask

  task automatic disp(input logic [6:0] op, input logic [4:0] rob, input logic [5:0] dest,
                      input logic [31:0] a, input logic ar, input logic [5:0] at,
                      input logic [31:0] b, input logic br, input logic [5:0] bt);
    bus.disp_valid_i = 1; bus.disp_op_i = op; bus.disp_rob_i = rob; bus.disp_dest_i = dest;
    bus.disp_a_i = a; bus.disp_a_rdy_i = ar; bus.disp_a_tag_i = at;
    bus.disp_b_i = b; bus.disp_b_rdy_i = br; bus.disp_b_tag_i = bt;
  endtask

  task automatic wk(input int port, input logic [5:0] tag, input logic [31:0] data);
    if (port == 0) begin bus.wk0_valid_i = 1; bus.wk0_tag_i = tag; bus.wk0_data_i = data; end
    else           begin bus.wk1_valid_i = 1; bus.wk1_tag_i = tag; bus.wk1_data_i = data; end
  endtask

  // operand after this cycle's broadcasts: {ready, value}
  function automatic logic [32:0] resolve(input logic r, input logic [5:0] t, input logic [31:0] v);
    if (r || t == 0) return {1'b1, v};
    if (bus.wk0_valid_i && bus.wk0_tag_i == t) return {1'b1, bus.wk0_data_i};
    if (bus.wk1_valid_i && bus.wk1_tag_i == t) return {1'b1, bus.wk1_data_i};
    return {1'b0, v};
  endfunction

  // one clock: update model from current inputs, clock, compare, clear inputs
  task automatic step();
    int          sel;
    bit          rdy;
    ent_t        e;
    logic [32:0] r;
    sel = -1;
    for (int i = 0; i < q.size(); i++) if (sel < 0 && q[i].ar && q[i].br) sel = i;
    rdy = q.size() < DEPTH;
    chk("disp_ready", {31'b0, bus.disp_ready_o}, {31'b0, rdy});
    if (bus.flush_i) begin
      q.delete();
      m_iv = 0;
    end else begin
      m_iv = sel >= 0;
      if (sel >= 0) begin
        m_a = q[sel].a; m_b = q[sel].b; m_op = q[sel].op; m_rob = q[sel].rob; m_dest = q[sel].dest;
      end
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        r = resolve(e.ar, e.at, e.a); e.ar = r[32]; e.a = r[31:0];
        r = resolve(e.br, e.bt, e.b); e.br = r[32]; e.b = r[31:0];
        q[i] = e;
      end
      if (sel >= 0) q.delete(sel);
      if (bus.disp_valid_i && rdy) begin
        e.op = bus.disp_op_i; e.rob = bus.disp_rob_i; e.dest = bus.disp_dest_i;
        e.at = bus.disp_a_tag_i; e.bt = bus.disp_b_tag_i;
        r = resolve(bus.disp_a_rdy_i, bus.disp_a_tag_i, bus.disp_a_i); e.ar = r[32]; e.a = r[31:0];
        r = resolve(bus.disp_b_rdy_i, bus.disp_b_tag_i, bus.disp_b_i); e.br = r[32]; e.b = r[31:0];
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    chk("iss_valid", {31'b0, bus.iss_valid_o}, {31'b0, m_iv});
    chk("iss_a", bus.iss_a_o, m_a);
    chk("iss_b", bus.iss_b_o, m_b);
    chk("iss_op", {25'b0, bus.iss_op_o}, {25'b0, m_op});
    chk("iss_rob", {27'b0, bus.iss_rob_o}, {27'b0, m_rob});
    chk("iss_dest", {26'b0, bus.iss_dest_o}, {26'b0, m_dest});
    chk("occupancy", {28'b0, bus.occupancy_o}, q.size());
    idle_in();
  endtask

  task automatic model_reset();
    q.delete();
    m_iv = 0; m_a = 0; m_b = 0; m_op = 0; m_rob = 0; m_dest = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.iss_valid_o}, 0);
    chk({tag, "_a"}, bus.iss_a_o, 0);
    chk({tag, "_b"}, bus.iss_b_o, 0);
    chk({tag, "_op"}, {25'b0, bus.iss_op_o}, 0);
    chk({tag, "_rob"}, {27'b0, bus.iss_rob_o}, 0);
    chk({tag, "_dest"}, {26'b0, bus.iss_dest_o}, 0);
    chk({tag, "_occ"}, {28'b0, bus.occupancy_o}, 0);
    chk({tag, "_ready"}, {31'b0, bus.disp_ready_o}, 1);
  endtask

  initial begin
    total = 0; bad = 0;
    idle_in();
    model_reset();
    rst_n = 0;
    #3 chk_reset_outs("rst");
    #9 rst_n = 1;                      // t=12, away from edges
    @(posedge clk); #1;

    // ready op: issues two cycles after dispatch
    disp(7'h00, 5'd3, 6'd9, 32'd5, 1, 6'd1, 32'd7, 1, 6'd2);
    step();
    chk("t1_occ1", {28'b0, bus.occupancy_o}, 1);
    step();
    chk("t1_valid", {31'b0, bus.iss_valid_o}, 1);
    chk("t1_a", bus.iss_a_o, 5);
    chk("t1_b", bus.iss_b_o, 7);
    chk("t1_rob", {27'b0, bus.iss_rob_o}, 3);
    chk("t1_dest", {26'b0, bus.iss_dest_o}, 9);
    chk("t1_occ0", {28'b0, bus.occupancy_o}, 0);

    // age order around a waiting older entry
    disp(7'h01, 5'd1, 6'd21, 32'd0, 0, 6'd12, 32'd1, 1, 6'd0); step();
    disp(7'h02, 5'd2, 6'd22, 32'd2, 1, 6'd0,  32'd2, 1, 6'd0); step();
    disp(7'h03, 5'd3, 6'd23, 32'd3, 1, 6'd0,  32'd3, 1, 6'd0); step();
    chk("t2_first", {27'b0, bus.iss_rob_o}, 2);
    step();
    chk("t2_second", {27'b0, bus.iss_rob_o}, 3);
    step();
    wk(0, 6'd12, 32'hDEAD); step();
    step();
    chk("t2_rob1", {27'b0, bus.iss_rob_o}, 1);
    chk("t2_a", bus.iss_a_o, 32'hDEAD);

    // dispatch-cycle bypass, port 0 wins
    disp(7'h04, 5'd4, 6'd24, 32'd9, 1, 6'd0, 32'd0, 0, 6'd20);
    wk(0, 6'd20, 32'h11); wk(1, 6'd20, 32'h22);
    step(); step();
    chk("t3_valid", {31'b0, bus.iss_valid_o}, 1);
    chk("t3_b", bus.iss_b_o, 32'h11);
    step();

    // fill, reject, drain oldest-first
    for (int i = 0; i < DEPTH; i++) begin
      disp(7'h05, 5'(10 + i), 6'(30 + i), 32'(i), 0, 6'd40, 32'(100 + i), 1, 6'd0);
      step();
    end
    chk("t4_full_rdy", {31'b0, bus.disp_ready_o}, 0);
    chk("t4_full_occ", {28'b0, bus.occupancy_o}, DEPTH);
    disp(7'h06, 5'd31, 6'd31, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0); step();
    wk(1, 6'd40, 32'hCAFE); step();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t4_drain_rob", {27'b0, bus.iss_rob_o}, 32'(10 + i));
    end
    step();

    // flush while a ready entry is being selected
    for (int i = 0; i < 3; i++) begin
      disp(7'h07, 5'(20 + i), 6'd1, 32'd0, 0, 6'd50, 32'd0, 1, 6'd0); step();
    end
    disp(7'h08, 5'd23, 6'd2, 32'd8, 1, 6'd0, 32'd8, 1, 6'd0); step();
    bus.flush_i = 1; step();
    chk("t5_valid", {31'b0, bus.iss_valid_o}, 0);
    chk("t5_occ", {28'b0, bus.occupancy_o}, 0);
    wk(0, 6'd50, 32'h5); step(); step(); step();
    chk("t5_nothing", {31'b0, bus.iss_valid_o}, 0);

    // async reset between edges
    disp(7'h09, 5'd5, 6'd5, 32'd5, 1, 6'd0, 32'd5, 1, 6'd0); step();
    disp(7'h0A, 5'd6, 6'd6, 32'd6, 0, 6'd7, 32'd6, 1, 6'd0); step();
    #3 rst_n = 0;
    #1 chk_reset_outs("mid_rst");
    model_reset();
    #2 rst_n = 1;
    idle_in();
    @(posedge clk); #1;
    // tag-0 operands always ready, tag-0 wakeup ignored
    disp(7'h0B, 5'd7, 6'd8, 32'h123, 0, 6'd0, 32'h456, 0, 6'd0);
    wk(0, 6'd0, 32'hBAD);
    step(); step();
    chk("t6_a", bus.iss_a_o, 32'h123);
    chk("t6_b", bus.iss_b_o, 32'h456);
    disp(7'h0C, 5'd8, 6'd9, 32'd0, 0, 6'd5, 32'd1, 1, 6'd0); step();
    wk(0, 6'd0, 32'hBAD); wk(1, 6'd0, 32'hBAD); step(); step();
    chk("t6_tag0_wk", {31'b0, bus.iss_valid_o}, 0);
    wk(0, 6'd5, 32'h77); step(); step();
    chk("t6_wake", bus.iss_a_o, 32'h77);

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 65)
        disp(7'($urandom), 5'($urandom), 6'($urandom), $urandom, 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) < 40) wk(0, 6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 99) < 40) wk(1, 6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 99) < 2) bus.flush_i = 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
